// File: rtl/pkt_phv_dispatcher.sv
// Pairs buffered AXI-Stream packets with their parsed header vectors in arrival order.
// Each packet is either forwarded with its egress port stamped into tuser, or dropped.
module pkt_phv_dispatcher #(
  parameter int         C_S_AXIS_DATA_WIDTH  = 256,
  parameter int         C_S_AXIS_TUSER_WIDTH = 128,
  parameter int         PHV_WIDTH            = 1124,
  parameter int         PKT_DEPTH_BITS       = 8,
  parameter int         PHV_DEPTH_BITS       = 4,
  parameter int         PORT_LSB             = 0,
  parameter int         DROP_BIT             = 8,
  parameter int         DST_LSB              = 24,
  parameter logic [7:0] DEFAULT_PORT         = 8'h04
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                                s_axis_tlast,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic [PHV_WIDTH-1:0]                phv_in,
  input  logic                                phv_valid,
  output logic                                phv_ready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [31:0]                         fwd_cnt,
  output logic [31:0]                         drop_cnt
);
  localparam int KW        = C_S_AXIS_DATA_WIDTH / 8;
  localparam int PKT_W     = C_S_AXIS_DATA_WIDTH + KW + C_S_AXIS_TUSER_WIDTH + 1;
  localparam int PKT_DEPTH = 1 << PKT_DEPTH_BITS;
  localparam int PHV_DEPTH = 1 << PHV_DEPTH_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DROP} state_t;

  state_t                            r_state;
  logic [PKT_W-1:0]                  r_pkt_mem [PKT_DEPTH];
  logic [PKT_DEPTH_BITS-1:0]         r_pkt_wptr, r_pkt_rptr;
  logic [PKT_DEPTH_BITS:0]           r_pkt_cnt;
  logic [8:0]                        r_phv_mem [PHV_DEPTH];
  logic [PHV_DEPTH_BITS-1:0]         r_phv_wptr, r_phv_rptr;
  logic [PHV_DEPTH_BITS:0]           r_phv_cnt;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    r_m_tdata;
  logic [KW-1:0]                     r_m_tkeep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   r_m_tuser;
  logic                              r_m_tlast, r_m_tvalid;
  logic [31:0]                       r_fwd_cnt, r_drop_cnt;

  logic                              w_pkt_wr, w_pkt_rd, w_phv_wr, w_phv_rd;
  logic                              w_pkt_nempty, w_phv_nempty, w_out_free;
  logic                              w_load, w_first;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    w_head_data;
  logic [KW-1:0]                     w_head_keep;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   w_head_user, w_out_user;
  logic                              w_head_last;
  logic [8:0]                        w_phv_head;
  logic                              w_phv_drop;
  logic [7:0]                        w_phv_port;
  logic                              w_unused_phv;

  // Nearly full means occupancy >= depth-1: either the top count bit or all low bits set.
  assign s_axis_tready = !(r_pkt_cnt[PKT_DEPTH_BITS] | (&r_pkt_cnt[PKT_DEPTH_BITS-1:0]));
  assign phv_ready     = !r_phv_cnt[PHV_DEPTH_BITS];
  assign w_pkt_wr      = s_axis_tvalid & s_axis_tready;
  assign w_phv_wr      = phv_valid & phv_ready;
  assign w_pkt_nempty  = (r_pkt_cnt != '0);
  assign w_phv_nempty  = (r_phv_cnt != '0);
  assign w_out_free    = !r_m_tvalid | m_axis_tready;

  // Only the port field and drop flag of the PHV are consumed downstream.
  assign w_unused_phv  = ^phv_in;
  assign {w_head_data, w_head_keep, w_head_user, w_head_last} = r_pkt_mem[r_pkt_rptr];
  assign w_phv_head    = r_phv_mem[r_phv_rptr];
  assign w_phv_drop    = w_phv_head[8];
  assign w_phv_port    = w_phv_head[7:0];

  // NOTE: storage arrays carry no reset; pointers and counts alone define FIFO contents.
  always_ff @(posedge clk) begin
    if (w_pkt_wr) r_pkt_mem[r_pkt_wptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    if (w_phv_wr) r_phv_mem[r_phv_wptr] <= {phv_in[DROP_BIT], phv_in[PORT_LSB +: 8]};
  end

  // NOTE: non-blocking assignments for every register so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_wptr <= '0;
      r_pkt_rptr <= '0;
      r_pkt_cnt  <= '0;
      r_phv_wptr <= '0;
      r_phv_rptr <= '0;
      r_phv_cnt  <= '0;
    end else begin
      if (w_pkt_wr) r_pkt_wptr <= r_pkt_wptr + PKT_DEPTH_BITS'(1);
      if (w_pkt_rd) r_pkt_rptr <= r_pkt_rptr + PKT_DEPTH_BITS'(1);
      if (w_phv_wr) r_phv_wptr <= r_phv_wptr + PHV_DEPTH_BITS'(1);
      if (w_phv_rd) r_phv_rptr <= r_phv_rptr + PHV_DEPTH_BITS'(1);
      r_pkt_cnt <= r_pkt_cnt + (PKT_DEPTH_BITS+1)'(w_pkt_wr) - (PKT_DEPTH_BITS+1)'(w_pkt_rd);
      r_phv_cnt <= r_phv_cnt + (PHV_DEPTH_BITS+1)'(w_phv_wr) - (PHV_DEPTH_BITS+1)'(w_phv_rd);
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
  always_comb begin
    w_phv_rd = 1'b0;
    w_pkt_rd = 1'b0;
    w_load   = 1'b0;
    w_first  = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_phv_nempty && w_pkt_nempty && w_out_free) begin
        w_phv_rd = 1'b1;
        if (!w_phv_drop) begin
          w_pkt_rd = 1'b1;
          w_load   = 1'b1;
          w_first  = 1'b1;
        end
      end
      ST_SEND: if (w_pkt_nempty && w_out_free) begin
        w_pkt_rd = 1'b1;
        w_load   = 1'b1;
      end
      ST_DROP: w_pkt_rd = w_pkt_nempty;
      default: ;
    endcase
  end

  always_comb begin
    w_out_user = w_head_user;
    if (w_first) w_out_user[DST_LSB +: 8] = (w_phv_port != 8'h00) ? w_phv_port : DEFAULT_PORT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= '0;
      r_m_tlast  <= 1'b0;
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_load) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_head_data;
        r_m_tkeep  <= w_head_keep;
        r_m_tuser  <= w_out_user;
        r_m_tlast  <= w_head_last;
      end else if (m_axis_tready) begin
        r_m_tvalid <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: if (w_phv_rd) begin
          if (w_phv_drop)       r_state   <= ST_DROP;
          else if (w_head_last) r_fwd_cnt <= r_fwd_cnt + 32'd1;
          else                  r_state   <= ST_SEND;
        end
        ST_SEND: if (w_pkt_rd && w_head_last) begin
          r_fwd_cnt <= r_fwd_cnt + 32'd1;
          r_state   <= ST_IDLE;
        end
        ST_DROP: if (w_pkt_rd && w_head_last) begin
          r_drop_cnt <= r_drop_cnt + 32'd1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tvalid = r_m_tvalid;
  assign fwd_cnt       = r_fwd_cnt;
  assign drop_cnt      = r_drop_cnt;
endmodule

// File: tb/tb_pkt_phv_dispatcher.sv
// Directed bench for pkt_phv_dispatcher: packet table plus latency, backpressure,
// FIFO-full and mid-packet reset sequences, checked against an in-order beat scoreboard.
`timescale 1ns/1ps
module tb_pkt_phv_dispatcher;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;
  localparam int PW = 1124;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    int         nbeats;
    logic [7:0] port;
    logic       drop;
    logic [7:0] exp_dst;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [PW-1:0] phv_in;
  logic          phv_valid, phv_ready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [31:0]   fwd_cnt, drop_cnt;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    hold_seen = 0;
  int    hold_bad = 0;
  int    exp_fwd = 0;
  int    exp_drop = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  vec_t  tbl[7];

  pkt_phv_dispatcher dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .phv_in(phv_in), .phv_valid(phv_valid), .phv_ready(phv_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk_beat(input int pid, input int b, input int n);
    beat_t      bt;
    logic [15:0] p16;
    logic [15:0] b16;
    p16     = pid[15:0];
    b16     = b[15:0];
    bt.data = {8{p16, b16}};
    bt.last = (b == n - 1);
    bt.keep = bt.last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    bt.user = {64'hDEAD_BEEF_0BAD_F00D, 24'h0, p16[7:0], 8'h77, 8'h00, p16[7:0], b16[7:0]};
    return bt;
  endfunction

  function automatic logic [PW-1:0] mk_phv(input logic [7:0] port, input logic drop);
    logic [PW-1:0] v;
    v             = '0;
    v[PW-1 -: 24] = 24'hABCDEF;
    v[15:9]       = 7'h55;
    v[8]          = drop;
    v[7:0]        = port;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input beat_t bt);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = bt.data;
    s_axis_tkeep  = bt.keep;
    s_axis_tuser  = bt.user;
    s_axis_tlast  = bt.last;
  endtask

  task automatic send_beat(input beat_t bt);
    int w;
    w = 0;
    drive_beat(bt);
    while (!s_axis_tready && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!s_axis_tready) check("s_axis_tready_wait", s_axis_tready, 1'b1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int pid, input int n);
    for (int b = 0; b < n; b++) send_beat(mk_beat(pid, b, n));
  endtask

  task automatic send_phv(input logic [7:0] port, input logic drop);
    int w;
    w = 0;
    while (!phv_ready && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!phv_ready) check("phv_ready_wait", phv_ready, 1'b1);
    phv_in    = mk_phv(port, drop);
    phv_valid = 1'b1;
    @(posedge clk); #1;
    phv_valid = 1'b0;
  endtask

  task automatic push_exp(input int pid, input int n, input logic [7:0] dst);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt = mk_beat(pid, b, n);
      if (b == 0) bt.user[31:24] = dst;
      exp_q.push_back(bt);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int w;
    w = 0;
    while (got_q.size() < exp_q.size() && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({name, "_beat_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_data[%0d]", name, i), got_q[i].data, exp_q[i].data);
      check($sformatf("%s_user[%0d]", name, i), got_q[i].user, exp_q[i].user);
      check($sformatf("%s_keep_last[%0d]", name, i), {got_q[i].keep, got_q[i].last},
            {exp_q[i].keep, exp_q[i].last});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // Output monitor: a beat is recorded on the falling edge before the rising edge that accepts it.
  logic          prev_hold = 1'b0;
  beat_t         prev_beat;
  always @(negedge clk) begin
    beat_t cur;
    cur.data = m_axis_tdata;
    cur.keep = m_axis_tkeep;
    cur.user = m_axis_tuser;
    cur.last = m_axis_tlast;
    if (prev_hold && !reset) begin
      hold_seen++;
      if (!m_axis_tvalid || cur.data !== prev_beat.data || cur.user !== prev_beat.user ||
          cur.keep !== prev_beat.keep || cur.last !== prev_beat.last) hold_bad++;
    end
    prev_hold = m_axis_tvalid && !m_axis_tready && !reset;
    prev_beat = cur;
    if (m_axis_tvalid && m_axis_tready && !reset) got_q.push_back(cur);
  end

  initial begin
    tbl[0] = '{3, 8'h10, 1'b0, 8'h10};
    tbl[1] = '{1, 8'h00, 1'b0, 8'h04};
    tbl[2] = '{2, 8'h22, 1'b0, 8'h22};
    tbl[3] = '{4, 8'h33, 1'b1, 8'h00};
    tbl[4] = '{2, 8'h00, 1'b0, 8'h04};
    tbl[5] = '{1, 8'h01, 1'b1, 8'h00};
    tbl[6] = '{1, 8'hFF, 1'b0, 8'hFF};

    reset         = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    phv_in        = '0;
    phv_valid     = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tdata", m_axis_tdata, '0);
    check("rst_m_tuser", m_axis_tuser, '0);
    check("rst_m_tkeep_tlast", {m_axis_tkeep, m_axis_tlast}, '0);
    check("rst_fwd_cnt", fwd_cnt, 32'd0);
    check("rst_drop_cnt", drop_cnt, 32'd0);
    check("rst_s_tready", s_axis_tready, 1'b1);
    check("rst_phv_ready", phv_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single 3-beat forward, first beat and PHV written in the same cycle.
    phv_in    = mk_phv(8'h10, 1'b0);
    phv_valid = 1'b1;
    drive_beat(mk_beat(1, 0, 3));
    @(posedge clk); #1;
    phv_valid = 1'b0;
    check("lat_not_yet_valid", m_axis_tvalid, 1'b0);
    drive_beat(mk_beat(1, 1, 3));
    @(posedge clk); #1;
    check("lat_valid_after_2", m_axis_tvalid, 1'b1);
    check("lat_first_dst", m_axis_tuser[31:24], 8'h10);
    drive_beat(mk_beat(1, 2, 3));
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    push_exp(1, 3, 8'h10);
    drain("single_fwd", 100);
    exp_fwd = 1;
    check("single_fwd_cnt", fwd_cnt, 32'd1);

    // Table of packets sent back to back: default port, single beats and drop interleave.
    for (int i = 0; i < 7; i++) begin
      send_phv(tbl[i].port, tbl[i].drop);
      send_pkt(10 + i, tbl[i].nbeats);
      if (tbl[i].drop) exp_drop++;
      else begin
        push_exp(10 + i, tbl[i].nbeats, tbl[i].exp_dst);
        exp_fwd++;
      end
    end
    drain("table", 200);
    check("table_fwd_cnt", fwd_cnt, 32'(exp_fwd));
    check("table_drop_cnt", drop_cnt, 32'(exp_drop));

    // Backpressure while sending: output must hold steady across stalled cycles.
    m_axis_tready = 1'b0;
    send_phv(8'h2B, 1'b0);
    send_pkt(40, 5);
    push_exp(40, 5, 8'h2B);
    m_axis_tready = 1'b1; @(posedge clk); #1;
    m_axis_tready = 1'b0; @(posedge clk); #1;
    m_axis_tready = 1'b0; @(posedge clk); #1;
    m_axis_tready = 1'b1;
    drain("backpressure", 100);
    exp_fwd++;
    check("bp_hold_seen", 32'(hold_seen > 0), 32'd1);
    check("bp_hold_bad", 32'(hold_bad), 32'd0);
    check("bp_fwd_cnt", fwd_cnt, 32'(exp_fwd));

    // Fill both FIFOs with the output stalled.
    m_axis_tready = 1'b0;
    for (int k = 0; k < 17; k++) send_pkt(100 + k, 15);
    check("full_s_tready_low", s_axis_tready, 1'b0);
    send_phv(8'h40, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("full_s_tready_back", s_axis_tready, 1'b1);
    for (int k = 1; k < 17; k++) send_phv(8'h40 + 8'(k), 1'b0);
    check("full_phv_ready_low", phv_ready, 1'b0);
    phv_in    = mk_phv(8'h7E, 1'b1);
    phv_valid = 1'b1;
    @(posedge clk); #1;
    phv_valid = 1'b0;
    for (int k = 0; k < 17; k++) push_exp(100 + k, 15, 8'h40 + 8'(k));
    m_axis_tready = 1'b1;
    drain("full_drain", 1000);
    exp_fwd += 17;
    check("full_fwd_cnt", fwd_cnt, 32'(exp_fwd));
    send_phv(8'h5A, 1'b0);
    send_pkt(200, 2);
    push_exp(200, 2, 8'h5A);
    drain("after_ignored_phv", 100);
    exp_fwd++;
    check("after_ignored_fwd_cnt", fwd_cnt, 32'(exp_fwd));
    check("after_ignored_drop_cnt", drop_cnt, 32'(exp_drop));

    // Reset while the third beat of a 5-beat packet is being presented.
    send_phv(8'h21, 1'b0);
    send_beat(mk_beat(300, 0, 5));
    send_beat(mk_beat(300, 1, 5));
    drive_beat(mk_beat(300, 2, 5));
    #2;
    reset = 1'b1;
    #1;
    check("midrst_tvalid_low", m_axis_tvalid, 1'b0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_fwd_cnt_zero", fwd_cnt, 32'd0);
    check("midrst_drop_cnt_zero", drop_cnt, 32'd0);
    drain("midrst_no_tail", 20);
    send_phv(8'h66, 1'b0);
    send_pkt(301, 2);
    push_exp(301, 2, 8'h66);
    drain("post_reset", 100);
    check("post_reset_fwd_cnt", fwd_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_phv_dispatcher.md
# pkt_phv_dispatcher

Parametrised successor to the pass-through processing stage. Buffers incoming AXI-Stream packets and their parsed header vectors (PHVs) in two internal FIFOs, then pairs each packet with its PHV in order. Per packet, the PHV selects one of two actions: forward, with the egress port taken from a PHV field and stamped into tuser, or drop. Sits between packet_header_parser and the output arbiter.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, tdata width; tkeep is C_S_AXIS_DATA_WIDTH/8
- C_S_AXIS_TUSER_WIDTH, 128, tuser width
- PHV_WIDTH, 1124, PHV width
- PKT_DEPTH_BITS, 8, packet FIFO depth is 2^PKT_DEPTH_BITS beats
- PHV_DEPTH_BITS, 4, PHV FIFO depth is 2^PHV_DEPTH_BITS entries
- PORT_LSB, 0, LSB of the 8-bit egress-port field in the PHV
- DROP_BIT, 8, PHV bit index of the drop flag
- DST_LSB, 24, LSB of the 8-bit destination field in tuser
- DEFAULT_PORT, 8'h04, egress port used when the PHV port field is 0

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- s_axis_tdata/tkeep/tuser/tlast  in  per params  ingress beat
- s_axis_tvalid  in  1
- s_axis_tready  out  1  = !pkt_nearly_full
- phv_in  in  PHV_WIDTH  parsed header
- phv_valid  in  1  PHV write strobe
- phv_ready  out  1  = !phv_full; phv_valid while phv_ready is low is discarded
- m_axis_tdata/tkeep/tuser/tlast  out  per params  registered egress beat
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- fwd_cnt  out  32  forwarded packets, wraps
- drop_cnt  out  32  dropped packets, wraps

## Operation
- Packet FIFO write: s_axis_tvalid & s_axis_tready.
- pkt_nearly_full: occupancy ≥ 2^PKT_DEPTH_BITS − 1.
- PHV FIFO write: phv_valid & phv_ready.
- Both FIFOs are fall-through. Simultaneous read and write is legal at any occupancy, including full and empty.
- State machine (IDLE, SEND, DROP):
  - IDLE: when both FIFOs are non-empty and the output register is free (!m_axis_tvalid | m_axis_tready), pop the PHV head.
  - On that pop, if phv[DROP_BIT] = 1: go to DROP. No beat is loaded.
  - Otherwise: load the first beat into the output register with tuser[DST_LSB+:8] = (port field ≠ 0 ? port field : DEFAULT_PORT); all other tuser bits pass through unchanged. Pop the beat, latch the port, go to SEND. If that beat has tlast, stay in IDLE and increment fwd_cnt.
  - SEND: each cycle the packet FIFO is non-empty and the output register is free, load and pop one beat. Only the first beat has tuser modified. On a beat with tlast: increment fwd_cnt, go to IDLE.
  - DROP: pop one beat per cycle while the packet FIFO is non-empty, regardless of m_axis_tready. On tlast: increment drop_cnt, go to IDLE.
- Output register holds all m_axis_* stable while m_axis_tvalid & !m_axis_tready.
- Packets leave in arrival order. PHV k always pairs with packet k.

## Timing
- Reset (asynchronous assert) clears:
  - Both FIFOs emptied.
  - State = IDLE.
  - m_axis_tvalid = 0, m_axis_tdata/tkeep/tuser = 0, m_axis_tlast = 0.
  - fwd_cnt = drop_cnt = 0.
  - s_axis_tready = 1, phv_ready = 1.
- Reset mid-packet: the partial packet is lost and no tail beats are emitted. Release is synchronous to clk.
- Latency: with both FIFOs empty and m_axis_tready = 1, the first output beat is valid 2 cycles after the later of the first-beat write and the PHV write.
- Throughput: after the first beat, one beat per cycle while the FIFO has data and m_axis_tready = 1. There is no bubble between back-to-back forwarded packets.
- One IDLE cycle per packet boundary is permitted only when the next PHV is not yet present.
- A drop takes (beat count) cycles. tvalid stays 0 for a drop unless a prior beat is still held in the output register.
- Counters update in the cycle after the tlast pop.

## Test plan
- Single forward: 3-beat packet, PHV port = 0x10, drop = 0 → 3 beats out; first beat tuser[31:24] = 0x10, other beats unchanged; fwd_cnt = 1; first beat 2 cycles after inputs.
- Default port and single beat: 1-beat packet (tlast on beat 0) with PHV port field 0 → one beat with tuser[31:24] = 0x04; state returns to IDLE with no SEND.
- Drop interleave: packets A (drop = 0), B (drop = 1, 4 beats), C (drop = 0) → only A then C appear, in order; drop_cnt = 1, fwd_cnt = 2.
- Backpressure: m_axis_tready toggling 1,0,0,1 during SEND → held beat stays stable and no beat is lost or duplicated.
- Full: with m_axis_tready = 0, stream 255 beats → s_axis_tready falls; PHV FIFO fills 16 entries → phv_ready = 0 and a 17th phv_valid is ignored; release tready → all data drains in order.
- Reset mid-packet: assert reset on beat 2 of 5 → m_axis_tvalid = 0 immediately; after release, a new packet forwards correctly and the counters read 0 before it.
